// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally and
// registers the returned word into an IF/ID register with a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] readAddress,
    input  logic [31:0] instructionIn,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    input  logic        readyIn,
    output logic        validOut,
    output logic [31:0] instructionOut,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4Out,
    output logic        halted,
    output logic        misaligned,
    output logic [15:0] fetchCount
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_END   = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc_out, w_pc_out_nxt;
    logic [31:0] r_pc4_out, w_pc4_out_nxt;
    logic        r_halted, w_halted_nxt;
    logic        r_misaligned, w_misaligned_nxt;
    logic [15:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic        w_past_end;
    logic        w_tgt_misaligned;
    logic        w_tgt_in_range;
    logic        w_advance;
    logic        w_handoff;

    // End-of-memory compares are done 33 bits wide so targets near 2^32 cannot wrap.
    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_past_end       = ({1'b0, r_pc} + 33'd4) > MEM_LIMIT;
    assign w_tgt_misaligned = |redirectTarget[1:0];
    assign w_tgt_in_range   = ({1'b0, redirectTarget} + 33'd4) <= MEM_LIMIT;
    assign w_advance        = !r_valid || readyIn;
    assign w_handoff        = r_valid && readyIn;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_valid;
        w_instr_nxt      = r_instr;
        w_pc_out_nxt     = r_pc_out;
        w_pc4_out_nxt    = r_pc4_out;
        w_halted_nxt     = r_halted;
        w_misaligned_nxt = r_misaligned;
        case (r_state)
            S_FETCH, S_HOLD: begin
                if (redirect) begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_WORD;
                    if (w_tgt_misaligned) begin
                        w_misaligned_nxt = 1'b1;
                        w_halted_nxt     = 1'b1;
                        w_state_nxt      = S_ERR;
                    end else begin
                        w_pc_nxt    = redirectTarget;
                        w_state_nxt = S_FETCH;
                    end
                end else if (w_advance) begin
                    if (w_past_end) begin
                        w_valid_nxt  = 1'b0;
                        w_instr_nxt  = NOP_WORD;
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = S_END;
                    end else begin
                        w_instr_nxt   = instructionIn;
                        w_pc_out_nxt  = r_pc;
                        w_pc4_out_nxt = w_pc_plus4;
                        w_valid_nxt   = 1'b1;
                        w_pc_nxt      = w_pc_plus4;
                        w_state_nxt   = S_FETCH;
                    end
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_END: begin
                // Only an aligned, in-range redirect restarts; everything else is ignored.
                if (redirect && !w_tgt_misaligned && w_tgt_in_range) begin
                    w_pc_nxt     = redirectTarget;
                    w_valid_nxt  = 1'b0;
                    w_instr_nxt  = NOP_WORD;
                    w_halted_nxt = 1'b0;
                    w_state_nxt  = S_FETCH;
                end else if (w_handoff) begin
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = NOP_WORD;
                end
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= NOP_WORD;
            r_pc_out     <= 32'd0;
            r_pc4_out    <= 32'd0;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_valid      <= w_valid_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_pc4_out    <= w_pc4_out_nxt;
            r_halted     <= w_halted_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    // Handoffs are counted in every state, including the edge a redirect lands on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 16'd0;
        end else if (w_handoff && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign readAddress    = r_pc;
    assign validOut       = r_valid;
    assign instructionOut = r_instr;
    assign pcOut          = r_pc_out;
    assign pcPlus4Out     = r_pc4_out;
    assign halted         = r_halted;
    assign misaligned     = r_misaligned;
    assign fetchCount     = r_fetch_count;

endmodule
